// File: rtl/rd_pipe_tracker_pkg.sv
// Shared definitions for the read-hazard pipeline tracker.
//   - opcode constants for branch and jalr
//   - FSM state encoding (RUN / HOLD)
//   - per-stage metadata record {rd, reg_write, load}
//   - stall counter width / saturation value
//   - helper deciding whether a tracked rd feeds either IF/ID source
package rd_pipe_tracker_pkg;

    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJalr   = 7'h67;

    localparam int unsigned CountWidth = 16;
    localparam logic [CountWidth-1:0] CountMax = '1;

    typedef enum logic {
        StRun,
        StHold
    } state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       load;
    } stage_meta_t;

    localparam stage_meta_t Bubble = '0;

    // x0 is hardwired to zero, so a tracked rd of 0 never creates a dependency.
    function automatic logic rd_hit(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/rd_pipe_tracker_if.sv
// Bundle between the decode stage and the hazard tracker.
//   master: the decode stage - drives the IF/ID instruction fields and flush,
//           receives the tracked stage metadata and stall controls.
//   slave:  the tracker itself.
// Signals:
//   ID_opCode, ID_rd, IF_ID_rs1, IF_ID_rs2, ID_regWrite, ID_load  IF/ID instruction
//   flush                                   redirect, squashes IF/ID
//   ID_EX_rd, EX_MEM_rd, MEM_WB_rd          tracked destinations
//   regWrite_ID_EX/EX_MEM/MEM_WB            tracked write enables
//   load_ID_EX, load_EX_MEM                 tracked load flags
//   stall, pcWrite, IF_ID_write             hazard controls
//   stall_count                             saturating stalled-cycle count
interface rd_pipe_tracker_if;

    logic [6:0]  ID_opCode;
    logic [4:0]  ID_rd;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic        ID_regWrite;
    logic        ID_load;
    logic        flush;

    logic [4:0]  ID_EX_rd;
    logic [4:0]  EX_MEM_rd;
    logic [4:0]  MEM_WB_rd;
    logic        regWrite_ID_EX;
    logic        regWrite_EX_MEM;
    logic        regWrite_MEM_WB;
    logic        load_ID_EX;
    logic        load_EX_MEM;
    logic        stall;
    logic        pcWrite;
    logic        IF_ID_write;
    logic [15:0] stall_count;

    modport master (
        output ID_opCode, ID_rd, IF_ID_rs1, IF_ID_rs2, ID_regWrite, ID_load, flush,
        input  ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
        input  regWrite_ID_EX, regWrite_EX_MEM, regWrite_MEM_WB,
        input  load_ID_EX, load_EX_MEM,
        input  stall, pcWrite, IF_ID_write, stall_count
    );

    modport slave (
        input  ID_opCode, ID_rd, IF_ID_rs1, IF_ID_rs2, ID_regWrite, ID_load, flush,
        output ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
        output regWrite_ID_EX, regWrite_EX_MEM, regWrite_MEM_WB,
        output load_ID_EX, load_EX_MEM,
        output stall, pcWrite, IF_ID_write, stall_count
    );

endinterface

// File: rtl/stage_meta_reg.sv
// One pipeline stage of tracked metadata {rd, reg_write, load}.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-low reset, clears to a bubble
//   bubble  synchronous: load a bubble instead of d on this edge
//   d       incoming metadata
//   q       registered metadata
module stage_meta_reg
    import rd_pipe_tracker_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        bubble,
    input  stage_meta_t d,
    output stage_meta_t q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= Bubble;
        end else if (bubble) begin
            q <= Bubble;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rd_pipe_tracker.sv
// Read-after-write hazard tracker for a 5-stage pipeline.
// Tracks {rd, regWrite, load} through ID/EX, EX/MEM and MEM/WB and stalls the
// IF/ID instruction when its sources are not yet available:
//   2 bubbles for load -> branch/jalr
//   1 bubble  for load-use, ALU -> branch/jalr, load-in-MEM -> branch/jalr
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    rd_pipe_tracker_if.slave (IF/ID fields, flush, tracked state, controls)
module rd_pipe_tracker
    import rd_pipe_tracker_pkg::*;
#(
    parameter logic [6:0] bOp    = OpBranch,
    parameter logic [6:0] jalrOp = OpJalr
) (
    input  logic             clock,
    input  logic             reset,
    rd_pipe_tracker_if.slave bus
);

    stage_meta_t id_in;
    stage_meta_t id_ex;
    stage_meta_t ex_mem;
    stage_meta_t mem_wb;

    state_e state_q;
    state_e state_d;

    logic                  stall;
    logic                  is_br;
    logic                  match_id_ex;
    logic                  match_ex_mem;
    logic                  need1;
    logic                  need2;
    logic [CountWidth-1:0] stall_count_q;

    assign id_in = '{rd: bus.ID_rd, reg_write: bus.ID_regWrite, load: bus.ID_load};

    // Tracker chain; only the ID/EX entry can be replaced by a bubble.
    stage_meta_reg u_id_ex (
        .clock  (clock),
        .reset  (reset),
        .bubble (stall | bus.flush),
        .d      (id_in),
        .q      (id_ex)
    );

    stage_meta_reg u_ex_mem (
        .clock  (clock),
        .reset  (reset),
        .bubble (1'b0),
        .d      (id_ex),
        .q      (ex_mem)
    );

    stage_meta_reg u_mem_wb (
        .clock  (clock),
        .reset  (reset),
        .bubble (1'b0),
        .d      (ex_mem),
        .q      (mem_wb)
    );

    // Hazard detection. Branches resolve in ID, so they need operands one stage
    // earlier than ordinary consumers, which read them in EX via forwarding.
    always_comb begin
        is_br        = (bus.ID_opCode == bOp) || (bus.ID_opCode == jalrOp);
        match_id_ex  = rd_hit(id_ex.rd, bus.IF_ID_rs1, bus.IF_ID_rs2);
        match_ex_mem = rd_hit(ex_mem.rd, bus.IF_ID_rs1, bus.IF_ID_rs2);
        need2        = is_br && id_ex.load && match_id_ex;
        need1        = (!is_br && id_ex.load && match_id_ex)
                    || (is_br && id_ex.reg_write && !id_ex.load && match_id_ex)
                    || (is_br && ex_mem.load && match_ex_mem);
    end

    // FSM: HOLD supplies the second bubble of a load -> branch dependency.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            StRun: begin
                stall = need1 | need2;
                if (need2) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                stall   = 1'b1;
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
        // A redirect squashes the dependent instruction, so nothing to wait for.
        if (bus.flush) begin
            stall   = 1'b0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != CountMax)) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign bus.ID_EX_rd        = id_ex.rd;
    assign bus.EX_MEM_rd       = ex_mem.rd;
    assign bus.MEM_WB_rd       = mem_wb.rd;
    assign bus.regWrite_ID_EX  = id_ex.reg_write;
    assign bus.regWrite_EX_MEM = ex_mem.reg_write;
    assign bus.regWrite_MEM_WB = mem_wb.reg_write;
    assign bus.load_ID_EX      = id_ex.load;
    assign bus.load_EX_MEM     = ex_mem.load;
    assign bus.stall           = stall;
    assign bus.pcWrite         = ~stall;
    assign bus.IF_ID_write     = ~stall;
    assign bus.stall_count     = stall_count_q;

    // MEM/WB load flag is tracked for completeness but has no consumer here.
    logic unused_mem_wb_load;
    assign unused_mem_wb_load = mem_wb.load;

endmodule
